// File: rtl/pattern_rx.sv
// rtl/pattern_rx.sv - serial blink-pattern receiver with frame compare and error count
module pattern_rx #(
  parameter int                     BIT_CYCLES  = 2097152,
  parameter int                     GAP_BITS    = 4,
  parameter int                     PATTERN_LEN = 32,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 32'h0547_7715
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   PIN_2,
  output logic                   LED,
  output logic [PATTERN_LEN-1:0] RX_WORD,
  output logic                   FRAME_VALID,
  output logic [7:0]             ERR_CNT,
  output logic                   USBPU
);

  localparam int PW = $clog2(BIT_CYCLES);
  localparam int IW = $clog2(PATTERN_LEN);
  localparam int GW = $clog2(GAP_BITS + 1);

  localparam logic [PW-1:0] PH_LAST  = PW'(BIT_CYCLES - 1);
  localparam logic [PW-1:0] PH_MID   = PW'(BIT_CYCLES / 2 - 1);
  localparam logic [GW-1:0] GAP_FULL = GW'(GAP_BITS);
  localparam logic [IW-1:0] IDX_LAST = IW'(PATTERN_LEN - 1);

  typedef enum logic [1:0] {
    S_HUNT  = 2'd0,
    S_RECV  = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   meta_q, line_q, line_d_q;
  logic                   line_edge, line_rise, strobe;
  logic [PW-1:0]          phase_q;
  logic [GW-1:0]          low_run_q;
  logic [IW-1:0]          bit_idx_q;
  logic [PATTERN_LEN-1:0] shreg_q;
  logic [PATTERN_LEN-1:0] word_cap;
  logic                   arm, last_bit;

  assign USBPU     = 1'b0;
  assign line_edge = line_q ^ line_d_q;
  assign line_rise = line_q & ~line_d_q;
  assign strobe    = ~line_edge & (phase_q == PH_MID);

  // Two-flop synchroniser plus a delayed copy for edge detection.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      meta_q   <= 1'b0;
      line_q   <= 1'b0;
      line_d_q <= 1'b0;
    end else begin
      meta_q   <= PIN_2;
      line_q   <= meta_q;
      line_d_q <= line_q;
    end
  end

  // Bit-phase counter; every line edge re-centres sampling on mid-bit.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      phase_q <= '0;
    end else if (line_edge || phase_q == PH_LAST) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_q + PW'(1);
    end
  end

  // Low-run tracks the line in every state, so a frame's own trailing zeros arm the next frame.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      low_run_q <= '0;
    end else if (line_q) begin
      low_run_q <= '0;
    end else if (strobe && low_run_q != GAP_FULL) begin
      low_run_q <= low_run_q + GW'(1);
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic plus frame-start and last-bit decodes.
  always_comb begin
    state_d  = state_q;
    arm      = 1'b0;
    last_bit = 1'b0;
    case (state_q)
      S_HUNT: begin
        if (line_rise && low_run_q == GAP_FULL) begin
          arm     = 1'b1;
          state_d = S_RECV;
        end
      end
      S_RECV: begin
        if (strobe && bit_idx_q == IDX_LAST) begin
          last_bit = 1'b1;
          state_d  = S_CHECK;
        end
      end
      S_CHECK: state_d = S_HUNT;
      default: state_d = S_HUNT;
    endcase
  end

  // Frame word including the bit sampled on the final strobe.
  always_comb begin
    word_cap            = shreg_q;
    word_cap[bit_idx_q] = line_q;
  end

  // Shift register: cleared on frame start, bit[index] written per strobe.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shreg_q   <= '0;
      bit_idx_q <= '0;
    end else if (arm) begin
      shreg_q   <= '0;
      bit_idx_q <= '0;
    end else if (state_q == S_RECV && strobe) begin
      shreg_q[bit_idx_q] <= line_q;
      bit_idx_q          <= bit_idx_q + IW'(1);
    end
  end

  // Result registers become visible in the CHECK cycle, together with the pulse.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RX_WORD     <= '0;
      LED         <= 1'b0;
      ERR_CNT     <= '0;
      FRAME_VALID <= 1'b0;
    end else begin
      FRAME_VALID <= last_bit;
      if (last_bit) begin
        RX_WORD <= word_cap;
        LED     <= (word_cap == PATTERN);
        if (word_cap != PATTERN && ERR_CNT != 8'hFF) begin
          ERR_CNT <= ERR_CNT + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pattern_rx.sv
// tb/tb_pattern_rx.sv - randomized self-checking bench for pattern_rx
module tb_pattern_rx;

  localparam logic [31:0] PAT = 32'h0547_7715;

  logic        CLK;
  logic        RST_N;
  logic        PIN_2;
  logic        LED;
  logic [31:0] RX_WORD;
  logic        FRAME_VALID;
  logic [7:0]  ERR_CNT;
  logic        USBPU;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] exp_q[$];
  int          fv_times[$];
  int          exp_err = 0;
  logic [31:0] mon_w;
  logic        fv_prev = 1'b0;

  pattern_rx #(
    .BIT_CYCLES (8),
    .GAP_BITS   (4),
    .PATTERN_LEN(32),
    .PATTERN    (PAT)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .PIN_2      (PIN_2),
    .LED        (LED),
    .RX_WORD    (RX_WORD),
    .FRAME_VALID(FRAME_VALID),
    .ERR_CNT    (ERR_CNT),
    .USBPU      (USBPU)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: each frame the stream sends while aligned is reported once, in order.
  always @(negedge CLK) begin
    if (fv_prev) chk("fv_one_cycle", FRAME_VALID, 1'b0);
    if (FRAME_VALID) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_fv", RX_WORD, 32'hxxxx_xxxx);
      end else begin
        mon_w = exp_q.pop_front();
        if (mon_w != PAT && exp_err < 255) exp_err++;
        chk("rx_word", RX_WORD, mon_w);
        chk("led", LED, (mon_w == PAT) ? 1'b1 : 1'b0);
        chk("err_cnt", ERR_CNT, exp_err);
        chk("usbpu", USBPU, 1'b0);
        fv_times.push_back(cyc);
      end
    end
    fv_prev = FRAME_VALID;
  end

  // jmode 0: 8-cycle bits; 1/2: alternate 7/9 starting with 7 or 9 on even bits.
  task automatic send_bits(input logic [31:0] w, input int lo, input int hi, input int jmode);
    int p;
    for (int i = lo; i <= hi; i++) begin
      if (jmode == 0) p = 8;
      else if (jmode == 1) p = (i % 2 == 0) ? 7 : 9;
      else p = (i % 2 == 0) ? 9 : 7;
      PIN_2 = w[i];
      repeat (p) @(negedge CLK);
    end
  endtask

  task automatic send_frame(input logic [31:0] w, input bit expect_it, input int jmode);
    if (expect_it) exp_q.push_back(w);
    send_bits(w, 0, 31, jmode);
  endtask

  task automatic drain();
    PIN_2 = 1'b0;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge CLK);
    chk("frames_pending", exp_q.size(), 0);
    exp_q.delete();
    repeat (40) @(negedge CLK);
  endtask

  // Called right after a falling edge: asserts reset between clock edges and checks outputs at once.
  task automatic reset_mid_cycle();
    #3 RST_N = 1'b0;
    #1;
    chk("rst_led", LED, 1'b0);
    chk("rst_rx_word", RX_WORD, 32'h0);
    chk("rst_fv", FRAME_VALID, 1'b0);
    chk("rst_err", ERR_CNT, 8'd0);
    chk("rst_usbpu", USBPU, 1'b0);
    exp_q.delete();
    exp_err = 0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int          jm;

    RST_N = 1'b0;
    PIN_2 = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    chk("init_led", LED, 1'b0);
    chk("init_rx_word", RX_WORD, 32'h0);
    chk("init_err", ERR_CNT, 8'd0);

    // Clean stream: 40 low cycles then three contiguous frames.
    repeat (40) @(negedge CLK);
    fv_times.delete();
    for (int f = 0; f < 3; f++) send_frame(PAT, 1'b1, 0);
    drain();
    chk("clean_fv_count", fv_times.size(), 3);
    if (fv_times.size() >= 3) begin
      chk("clean_gap_1", fv_times[1] - fv_times[0], 256);
      chk("clean_gap_2", fv_times[2] - fv_times[1], 256);
    end
    chk("clean_led", LED, 1'b1);
    chk("clean_err", ERR_CNT, 8'd0);

    // Corruption of bit 5, then a good frame.
    w = PAT;
    w[5] = ~w[5];
    send_frame(w, 1'b1, 0);
    send_frame(PAT, 1'b1, 0);
    drain();
    chk("corrupt_err_hold", ERR_CNT, 8'd1);
    chk("corrupt_led_back", LED, 1'b1);

    // Jitter: alternating 7/9-cycle bit periods.
    jm = $urandom_range(2, 1);
    for (int f = 0; f < 3; f++) send_frame(PAT, 1'b1, jm);
    drain();
    chk("jitter_led", LED, 1'b1);

    // Saturation: randomly corrupted frames with random timing mode.
    for (int f = 0; f < 300; f++) begin
      w = PAT;
      w[$urandom_range(26, 1)] ^= 1'b1;
      send_frame(w, 1'b1, $urandom_range(2, 0));
    end
    drain();
    chk("err_saturated", ERR_CNT, 8'd255);
    chk("sat_led", LED, 1'b0);

    // Mid-frame start: reset released at frame bit 9.
    reset_mid_cycle();
    send_bits(PAT, 0, 8, 0);
    RST_N = 1'b1;
    send_bits(PAT, 9, 31, 0);
    send_frame(PAT, 1'b1, 0);
    drain();
    chk("midstart_led", LED, 1'b1);
    chk("midstart_err", ERR_CNT, 8'd0);

    // Reset during reception at bit 15, then the stream continues.
    w = PAT;
    w[$urandom_range(26, 1)] ^= 1'b1;
    send_frame(w, 1'b1, 0);
    send_bits(PAT, 0, 14, 0);
    PIN_2 = PAT[15];
    @(negedge CLK);
    reset_mid_cycle();
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (5) @(negedge CLK);
    send_bits(PAT, 16, 31, 0);
    send_frame(PAT, 1'b1, 0);
    drain();
    chk("recv_reset_led", LED, 1'b1);
    chk("recv_reset_word", RX_WORD, PAT);
    chk("recv_reset_err", ERR_CNT, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
